// File: rtl/multiciclo_control.sv
// Main control FSM of the multicycle MIPS datapath: sequences fetch/decode/execute/memory/write-back.
// Optional MC_MEM_WAIT_EN adds mem_ready and stalls FETCH, MEMRD and MEMWR until memory is ready.
module multiciclo_control #(
    parameter int unsigned STATE_W = 4,
    parameter int unsigned OP_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    opcode,
    input  logic [OP_W-1:0]    funct,
    input  logic               Zero,
`ifdef MC_MEM_WAIT_EN
    input  logic               mem_ready,
`endif
    output logic               pc_en,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [3:0]         operation,
    output logic [STATE_W-1:0] state,
    output logic               illegal
);

    localparam logic [OP_W-1:0] OpRtype = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OpJ     = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OpBeq   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OpAddi  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OpLw    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OpSw    = OP_W'(6'b101011);

    localparam logic [OP_W-1:0] FnAdd = OP_W'(6'b100000);
    localparam logic [OP_W-1:0] FnSub = OP_W'(6'b100010);
    localparam logic [OP_W-1:0] FnAnd = OP_W'(6'b100100);
    localparam logic [OP_W-1:0] FnOr  = OP_W'(6'b100101);
    localparam logic [OP_W-1:0] FnSlt = OP_W'(6'b101010);
    localparam logic [OP_W-1:0] FnNor = OP_W'(6'b100111);

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;
    localparam logic [3:0] AluNor = 4'b1100;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11
    } state_e;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   pc_write, branch, mem_rdy;

`ifdef MC_MEM_WAIT_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        pc_write  = 1'b0;
        branch    = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        PCSource  = 2'b00;
        operation = AluAdd;
        case (state_q)
            StFetch: begin
                // IR and PC load only on the ready cycle so a stall cannot double-advance the PC
                MemRead  = 1'b1;
                IRWrite  = mem_rdy;
                pc_write = mem_rdy;
                ALUSrcB  = 2'b01;
                if (mem_rdy) state_d = StDecode;
            end
            StDecode: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExec;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJump;
                    default: begin
                        state_d   = StFetch;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (opcode == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_rdy) state_d = StMemWb;
            end
            StMemWb: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = StFetch;
            end
            StMemWr: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_rdy) state_d = StFetch;
            end
            StExec: begin
                ALUSrcA = 1'b1;
                state_d = StAluWb;
                case (funct)
                    FnAdd:   operation = AluAdd;
                    FnSub:   operation = AluSub;
                    FnAnd:   operation = AluAnd;
                    FnOr:    operation = AluOr;
                    FnSlt:   operation = AluSlt;
                    FnNor:   operation = AluNor;
                    default: illegal_d = 1'b1;
                endcase
            end
            StAluWb: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = StFetch;
            end
            StBranch: begin
                ALUSrcA   = 1'b1;
                operation = AluSub;
                branch    = 1'b1;
                PCSource  = 2'b01;
                state_d   = StFetch;
            end
            StAddiEx: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = StAddiWb;
            end
            StAddiWb: begin
                RegWrite = 1'b1;
                state_d  = StFetch;
            end
            StJump: begin
                pc_write = 1'b1;
                PCSource = 2'b10;
                state_d  = StFetch;
            end
            default: state_d = StFetch;
        endcase

        pc_en = pc_write | (branch & Zero);

        // Outputs are forced quiet while reset is held so an aborted instruction issues no writes
        if (!rst) begin
            pc_en     = 1'b0;
            IorD      = 1'b0;
            MemRead   = 1'b0;
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            RegDst    = 1'b0;
            MemtoReg  = 1'b0;
            RegWrite  = 1'b0;
            ALUSrcA   = 1'b0;
            ALUSrcB   = 2'b00;
            PCSource  = 2'b00;
            operation = 4'b0000;
        end
    end

    assign state   = STATE_W'(state_q);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_multiciclo_control.sv
// Self-checking bench for multiciclo_control: random instruction stream against a
// per-instruction state-sequence and control-table model.
module tb_multiciclo_control;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       Zero = 1'b0;
`ifdef MC_MEM_WAIT_EN
    logic       mem_ready = 1'b1;
`endif
    logic       pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] operation, state;
    logic       illegal;

    int n_chk = 0;
    int n_err = 0;
    logic model_ill = 1'b0;

    multiciclo_control dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .funct     (funct),
        .Zero      (Zero),
`ifdef MC_MEM_WAIT_EN
        .mem_ready (mem_ready),
`endif
        .pc_en     (pc_en),
        .IorD      (IorD),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .PCSource  (PCSource),
        .operation (operation),
        .state     (state),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Expected controls per state; -1 = unspecified, -2 = operation comes from funct.
    typedef struct {
        int mr, mw, ir, rw, pcw, br, iord, rdst, m2r, srca, srcb, pcsrc, op;
    } ctrl_t;
    ctrl_t tbl [12];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int funct_op(input logic [5:0] f);
        case (f)
            6'b100000: return 2;
            6'b100010: return 6;
            6'b100100: return 0;
            6'b100101: return 1;
            6'b101010: return 7;
            6'b100111: return 12;
            default:   return 2;
        endcase
    endfunction

    function automatic bit funct_ok(input logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    endfunction

    task automatic seq_of(input logic [5:0] op, output int q[$]);
        case (op)
            6'b100011: q = '{0, 1, 2, 3, 4};
            6'b101011: q = '{0, 1, 2, 5};
            6'b000000: q = '{0, 1, 6, 7};
            6'b000100: q = '{0, 1, 8};
            6'b001000: q = '{0, 1, 9, 10};
            6'b000010: q = '{0, 1, 11};
            default:   q = '{0, 1};
        endcase
    endtask

    task automatic opt_chk(input string tag, input logic [31:0] obs, input int exp);
        if (exp >= 0) chk(tag, obs, 32'(exp));
    endtask

    // Run the first nsteps cycles of one instruction; entered and left at a falling edge.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int nsteps);
        int    q[$];
        ctrl_t c;
        int    s;
        seq_of(op, q);
        for (int i = 0; i < q.size() && i < nsteps; i++) begin
            s = q[i];
            c = tbl[s];
            opcode = op;
            funct  = fn;
            Zero   = z;
            #1;
            chk("state", 32'(state), 32'(s));
            chk("illegal", 32'(illegal), 32'(model_ill));
            chk("pc_en", 32'(pc_en), 32'(c.pcw | (c.br & int'(z))));
            chk("MemRead", 32'(MemRead), 32'(c.mr));
            chk("MemWrite", 32'(MemWrite), 32'(c.mw));
            chk("IRWrite", 32'(IRWrite), 32'(c.ir));
            chk("RegWrite", 32'(RegWrite), 32'(c.rw));
            opt_chk("IorD", 32'(IorD), c.iord);
            opt_chk("RegDst", 32'(RegDst), c.rdst);
            opt_chk("MemtoReg", 32'(MemtoReg), c.m2r);
            opt_chk("ALUSrcA", 32'(ALUSrcA), c.srca);
            opt_chk("ALUSrcB", 32'(ALUSrcB), c.srcb);
            opt_chk("PCSource", 32'(PCSource), c.pcsrc);
            opt_chk("operation", 32'(operation), (c.op == -2) ? funct_op(fn) : c.op);
            if (s == 1 && q.size() == 2) model_ill = 1'b1;
            if (s == 6 && !funct_ok(fn)) model_ill = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_strobes", {27'd0, pc_en, MemRead, MemWrite, IRWrite, RegWrite}, 32'd0);
        chk("rst_selects", {24'd0, IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_ill = 1'b0;
    endtask

    logic [5:0] ops [6];
    logic [5:0] fns [6];

    initial begin
        tbl[0]  = '{1, 0, 1, 0, 1, 0, -1, -1, -1, 0, 1, 0, 2};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, -1, -1, -1, 0, 3, -1, 2};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, -1, -1, -1, 1, 2, -1, 2};
        tbl[3]  = '{1, 0, 0, 0, 0, 0, 1, -1, -1, -1, -1, -1, -1};
        tbl[4]  = '{0, 0, 0, 1, 0, 0, -1, 0, 1, -1, -1, -1, -1};
        tbl[5]  = '{0, 1, 0, 0, 0, 0, 1, -1, -1, -1, -1, -1, -1};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, -1, -1, -1, 1, 0, -1, -2};
        tbl[7]  = '{0, 0, 0, 1, 0, 0, -1, 1, 0, -1, -1, -1, -1};
        tbl[8]  = '{0, 0, 0, 0, 0, 1, -1, -1, -1, 1, 0, 1, 6};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, -1, -1, -1, 1, 2, -1, 2};
        tbl[10] = '{0, 0, 0, 1, 0, 0, -1, 0, 0, -1, -1, -1, -1};
        tbl[11] = '{0, 0, 0, 0, 1, 0, -1, -1, -1, -1, -1, 2, -1};
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};

        @(negedge clk);
        do_reset();

        // Directed: lw, R-type sub, beq taken/not taken
        run_instr(6'b100011, 6'd0, 1'b0, 99);
        run_instr(6'b000000, 6'b100010, 1'b0, 99);
        run_instr(6'b000100, 6'd0, 1'b1, 99);
        run_instr(6'b000100, 6'd0, 1'b0, 99);

        // Illegal opcode is sticky across a following add, cleared by reset
        run_instr(6'b111111, 6'd0, 1'b0, 99);
        run_instr(6'b000000, 6'b100000, 1'b0, 99);
        do_reset();

        // Bad funct still writes back and flags illegal
        run_instr(6'b000000, 6'b111000, 1'b0, 99);
        do_reset();

        // Reset in the middle of lw aborts before any write strobe
        run_instr(6'b100011, 6'd0, 1'b0, 3);
        do_reset();

`ifdef MC_MEM_WAIT_EN
        // Stall FETCH and MEMWR of a sw for 3 cycles each
        opcode = 6'b101011;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_fetch_state", 32'(state), 32'd0);
            chk("stall_fetch_pc_en", 32'(pc_en), 32'd0);
            chk("stall_fetch_irw", 32'(IRWrite), 32'd0);
            chk("stall_fetch_mr", 32'(MemRead), 32'd1);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        chk("ready_fetch_pc_en", 32'(pc_en), 32'd1);
        chk("ready_fetch_irw", 32'(IRWrite), 32'd1);
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            chk("memwr_state", 32'(state), 32'd5);
            chk("memwr_mw", 32'(MemWrite), 32'd1);
            @(negedge clk);
        end
        #1;
        chk("memwr_done", 32'(state), 32'd0);
        @(negedge clk);
        do_reset();
`endif

        // Random instruction stream, occasional reset
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op, fn;
            int k;
            k  = int'($urandom_range(0, 7));
            op = (k < 6) ? ops[k] : ((k == 6) ? 6'b000000 : 6'(($urandom_range(0, 1) != 0) ?
                 6'b111111 : 6'b001111));
            fn = ($urandom_range(0, 7) == 0) ? 6'b110011 : fns[$urandom_range(0, 5)];
            run_instr(op, fn, 1'($urandom_range(0, 1)), 99);
            if (n % 12 == 11) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
